// File: rtl/mux_serializer_pkg.sv
// Shared types and widths for the mux serializer slice.
// State codes keep the numeric values used by the original encoding.
package mux_serializer_pkg;

   localparam int unsigned SEL_W  = 3;
   localparam int unsigned WORD_W = 8;
   localparam int unsigned GAP_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

endpackage

// File: rtl/mux_serializer_mux8to1.sv
// 8:1 bit multiplexer: picks in[sel] onto cout.
module mux8to1
   import mux_serializer_pkg::*;
(
   input  logic [WORD_W-1:0] in,
   input  logic [SEL_W-1:0]  sel,
   output logic              cout
);

   always_comb cout = in[sel];

endmodule

// File: rtl/mux_serializer.sv
// Parallel-to-serial stage: latches a word, then walks the mux select through
// all eight bit positions with valid/ready on both sides and frame markers.
module mux_serializer
   import mux_serializer_pkg::*;
#(
   parameter bit          MSB_FIRST = 1'b0,
   parameter int unsigned GAP       = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ser_out,
   output logic              ser_valid,
   input  logic              ser_ready,
   output logic              ser_first,
   output logic              ser_last,
   output logic [SEL_W-1:0]  sel,
   output logic              busy
);

   localparam logic [SEL_W-1:0] SEL_START = MSB_FIRST ? '1 : '0;
   localparam logic [SEL_W-1:0] SEL_END   = MSB_FIRST ? '0 : '1;
   localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1);
   localparam logic [GAP_W-1:0] GAP_LAST  = (GAP == 0) ? '0 : GAP_W'(GAP - 1);
   localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
   localparam bit               HAS_GAP   = (GAP != 0);

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic                last_beat;
   logic                in_xfer;

   always_comb begin
      last_beat = (state_q == ST_SHIFT) && (sel_q == SEL_END);
      // ser_ready feeds in_ready directly so a new word can follow the last bit
      in_ready  = !rst && ((state_q == ST_IDLE) ||
                           (last_beat && ser_ready && !HAS_GAP));
      in_xfer   = in_valid && in_ready;
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      sel_d   = sel_q;
      gap_d   = gap_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_xfer) begin
               word_d  = in_data;
               sel_d   = SEL_START;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (ser_ready) begin
               if (sel_q == SEL_END) begin
                  // frame end is a compare; sel is reloaded rather than wrapped
                  sel_d = SEL_START;
                  if (HAS_GAP) begin
                     gap_d   = '0;
                     state_d = ST_GAP;
                  end else if (in_xfer) begin
                     word_d  = in_data;
                     state_d = ST_SHIFT;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else if (MSB_FIRST) begin
                  sel_d = sel_q - SEL_ONE;
               end else begin
                  sel_d = sel_q + SEL_ONE;
               end
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + GAP_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = SEL_START;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
         sel_q   <= SEL_START;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         sel_q   <= sel_d;
         gap_q   <= gap_d;
      end
   end

   always_comb begin
      ser_valid = (state_q == ST_SHIFT);
      ser_first = (state_q == ST_SHIFT) && (sel_q == SEL_START);
      ser_last  = (state_q == ST_SHIFT) && (sel_q == SEL_END);
      busy      = (state_q == ST_SHIFT) || (state_q == ST_GAP);
      sel       = sel_q;
   end

   mux8to1 u_mux (
      .in   (word_q),
      .sel  (sel_q),
      .cout (ser_out)
   );

endmodule

// File: tb/tb_mux_serializer.sv
// Directed bench for mux_serializer: LSB-first/no-gap vectors from a table,
// plus a hand-written MSB-first frame with a two-cycle gap.
module tb_mux_serializer;

   logic       clk;
   logic       rst_a, in_valid_a, in_ready_a, ser_out_a, ser_valid_a, ser_ready_a;
   logic       ser_first_a, ser_last_a, busy_a;
   logic [7:0] in_data_a;
   logic [2:0] sel_a;

   logic       rst_b, in_valid_b, in_ready_b, ser_out_b, ser_valid_b, ser_ready_b;
   logic       ser_first_b, ser_last_b, busy_b;
   logic [7:0] in_data_b;
   logic [2:0] sel_b;

   int unsigned checks = 0;
   int unsigned errors = 0;

   typedef struct {
      logic       rst;
      logic       iv;
      logic [7:0] d;
      logic       sr;
      logic       ir;
      logic       sv;
      logic       so;
      logic       sf;
      logic       sl;
      logic [2:0] sel;
      logic       bz;
   } vec_t;

   vec_t vecs[$];

   mux_serializer dut_a (
      .clk(clk), .rst(rst_a), .in_data(in_data_a), .in_valid(in_valid_a),
      .in_ready(in_ready_a), .ser_out(ser_out_a), .ser_valid(ser_valid_a),
      .ser_ready(ser_ready_a), .ser_first(ser_first_a), .ser_last(ser_last_a),
      .sel(sel_a), .busy(busy_a)
   );

   mux_serializer #(.MSB_FIRST(1'b1), .GAP(2)) dut_b (
      .clk(clk), .rst(rst_b), .in_data(in_data_b), .in_valid(in_valid_b),
      .in_ready(in_ready_b), .ser_out(ser_out_b), .ser_valid(ser_valid_b),
      .ser_ready(ser_ready_b), .ser_first(ser_first_b), .ser_last(ser_last_b),
      .sel(sel_b), .busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int unsigned idx,
                      input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic addv(input logic rst, input logic iv, input logic [7:0] d,
                       input logic sr, input logic ir, input logic sv,
                       input logic so, input logic sf, input logic sl,
                       input logic [2:0] sel, input logic bz);
      vec_t v;
      v.rst = rst; v.iv = iv; v.d = d; v.sr = sr; v.ir = ir; v.sv = sv;
      v.so = so; v.sf = sf; v.sl = sl; v.sel = sel; v.bz = bz;
      vecs.push_back(v);
   endtask

   // One LSB-first frame of word w; optional stall of stall_n cycles before bit stall_at.
   task automatic add_frame(input logic [7:0] w, input logic iv, input logic [7:0] d,
                            input int stall_at, input int stall_n, input int nbits);
      for (int k = 0; k < nbits; k++) begin
         if (k == stall_at)
            for (int s = 0; s < stall_n; s++)
               addv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, w[k], k == 0, k == 7, 3'(k), 1'b1);
         addv(1'b0, iv, d, 1'b1, k == 7, 1'b1, w[k], k == 0, k == 7, 3'(k), 1'b1);
      end
   endtask

   initial begin
      logic [7:0] wb;
      rst_a = 1'b1; in_valid_a = 1'b0; in_data_a = 8'h00; ser_ready_a = 1'b1;
      rst_b = 1'b1; in_valid_b = 1'b0; in_data_b = 8'h00; ser_ready_b = 1'b1;

      // reset held with in_valid high, then release
      for (int i = 0; i < 3; i++)
         addv(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      addv(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      // single frame 8'b11010101
      addv(1'b0, 1'b1, 8'hD5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      add_frame(8'hD5, 1'b0, 8'h00, -1, 0, 8);
      // back-to-back A5 then 3C; 3C offered during the whole A5 frame
      addv(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
      add_frame(8'hA5, 1'b1, 8'h3C, -1, 0, 8);
      add_frame(8'h3C, 1'b0, 8'h00, -1, 0, 8);
      // backpressure for 3 cycles at sel=3
      addv(1'b0, 1'b1, 8'hD5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      add_frame(8'hD5, 1'b0, 8'h00, 3, 3, 8);
      // reset at sel=4, then FF
      addv(1'b0, 1'b1, 8'hD5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
      add_frame(8'hD5, 1'b0, 8'h00, -1, 0, 4);
      addv(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1);
      addv(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      add_frame(8'hFF, 1'b0, 8'h00, -1, 0, 8);
      addv(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

      repeat (2) @(posedge clk);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst_a = vecs[i].rst; in_valid_a = vecs[i].iv;
         in_data_a = vecs[i].d; ser_ready_a = vecs[i].sr;
         #1;
         chk("in_ready",  i, in_ready_a,  vecs[i].ir);
         chk("ser_valid", i, ser_valid_a, vecs[i].sv);
         chk("ser_out",   i, ser_out_a,   vecs[i].so);
         chk("ser_first", i, ser_first_a, vecs[i].sf);
         chk("ser_last",  i, ser_last_a,  vecs[i].sl);
         chk("sel",       i, sel_a,       vecs[i].sel);
         chk("busy",      i, busy_a,      vecs[i].bz);
      end

      // MSB-first with GAP=2
      @(negedge clk);
      #1;
      chk("b_rst_sel",   0, sel_b,       8'd7);
      chk("b_rst_valid", 0, ser_valid_b, 1'b0);
      chk("b_rst_ready", 0, in_ready_b,  1'b0);
      @(negedge clk);
      rst_b = 1'b0; in_valid_b = 1'b1; in_data_b = 8'hD5;
      #1;
      chk("b_idle_ready", 0, in_ready_b, 1'b1);
      wb = 8'hD5;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         in_valid_b = 1'b0; in_data_b = 8'h00;
         #1;
         chk("b_valid", k, ser_valid_b, 1'b1);
         chk("b_out",   k, ser_out_b,   wb[7-k]);
         chk("b_sel",   k, sel_b,       8'(7 - k));
         chk("b_first", k, ser_first_b, k == 0);
         chk("b_last",  k, ser_last_b,  k == 7);
         chk("b_ready", k, in_ready_b,  1'b0);
      end
      for (int g = 0; g < 2; g++) begin
         @(negedge clk);
         #1;
         chk("b_gap_valid", g, ser_valid_b, 1'b0);
         chk("b_gap_ready", g, in_ready_b,  1'b0);
         chk("b_gap_busy",  g, busy_b,      1'b1);
      end
      @(negedge clk);
      #1;
      chk("b_end_ready", 0, in_ready_b, 1'b1);
      chk("b_end_busy",  0, busy_b,     1'b0);
      chk("b_end_sel",   0, sel_b,      8'd7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
